// File: rtl/sb_stream_add_stage_pkg.sv
// sb_stream_pkg: shared types for the switchboard add stage.
//   sb_state_e : stage control states (RUN, DRAIN, DONE)
//   sb_beat_t  : packed stream beat {data, dest, last}, data width SB_DW
//   is_eos()   : true for the all-ones end-of-stream beat
package sb_stream_pkg;

  localparam int SB_DW = 256;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic [SB_DW-1:0] data;
    logic [31:0]      dest;
    logic             last;
  } sb_beat_t;

  function automatic logic is_eos(input logic [SB_DW-1:0] data);
    return &data;
  endfunction

endpackage

// File: rtl/sb_stream_add_stage_if.sv
// sb_stream_add_stage_if: one valid/ready stream link.
//   data  : beat data (DW bits)
//   dest  : destination (32 bits)
//   last  : last-of-packet
//   valid : source has a beat
//   ready : sink can accept
// master = source side, slave = sink side.
interface sb_stream_add_stage_if #(
  parameter int DW = 256
);
  logic [DW-1:0] data;
  logic [31:0]   dest;
  logic          last;
  logic          valid;
  logic          ready;

  modport master (output data, dest, last, valid, input ready);
  modport slave  (input data, dest, last, valid, output ready);
endinterface

// File: rtl/sb_stream_add_stage_skid.sv
// sb_skid_buf: generic 2-entry valid/ready skid buffer.
//   clk, nreset   : clock, async active-low reset
//   i_push        : write i_data this cycle (caller guarantees !o_skid_valid)
//   i_data        : beat to store
//   o_valid/o_data: main register, drives the downstream side
//   i_ready       : downstream ready
//   o_skid_valid  : skid register occupied (upstream must stop)
//   o_empty       : both entries empty
module sb_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic         o_skid_valid,
  output logic         o_empty
);

  logic [W-1:0] r_main;
  logic         r_main_v;
  logic [W-1:0] r_skid;
  logic         r_skid_v;
  logic         w_main_free;

  // Main can take a new entry when empty or being popped this cycle.
  assign w_main_free = !r_main_v || i_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_main   <= '0;
      r_main_v <= 1'b0;
      r_skid   <= '0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      // Skid drains first to keep strict FIFO order.
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (i_push) begin
        r_main   <= i_data;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (i_push) begin
      r_skid   <= i_data;
      r_skid_v <= 1'b1;
    end
  end

  assign o_valid      = r_main_v;
  assign o_data       = r_main;
  assign o_skid_valid = r_skid_v;
  assign o_empty      = !r_main_v && !r_skid_v;

endmodule

// File: rtl/sb_stream_add_stage.sv
// sb_stream_add_stage: registered stream stage adding INCR to data[ADD_W-1:0].
//   clk, nreset : clock, async active-low reset
//   in_if       : upstream stream (slave), ready is registered-only
//   out_if      : downstream stream (master)
//   done        : sticky, EOS forwarded and buffer empty
//   beat_count  : accepted beats   (SB_STREAM_ADD_STATS_EN, else 0)
//   pkt_count   : accepted last=1  (SB_STREAM_ADD_STATS_EN, else 0)
// DW must equal sb_stream_pkg::SB_DW (beat struct width).
//
// state | meaning
// RUN   | accepting and transforming beats
// DRAIN | EOS accepted, input closed, emptying buffer
// DONE  | buffer empty after EOS, done=1 until reset
module sb_stream_add_stage
  import sb_stream_pkg::*;
#(
  parameter int               DW    = SB_DW,
  parameter int               ADD_W = 64,
  parameter logic [ADD_W-1:0] INCR  = 42
) (
  input  logic                   clk,
  input  logic                   nreset,
  sb_stream_add_stage_if.slave   in_if,
  sb_stream_add_stage_if.master  out_if,
  output logic                   done,
  output logic [31:0]            beat_count,
  output logic [31:0]            pkt_count
);

  sb_state_e        r_state;
  sb_state_e        w_next_state;
  logic             r_up;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_eos;
  logic [ADD_W-1:0] w_sum;
  sb_beat_t         w_beat;
  sb_beat_t         w_out;
  logic             w_skid_valid;
  logic             w_empty;

  // Holds in_ready low during reset and releases it one edge later.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_up <= 1'b0;
    else         r_up <= 1'b1;
  end

  assign w_accept = in_if.valid && w_in_ready;
  assign w_eos    = is_eos(in_if.data);

  always_comb begin
    w_sum       = in_if.data[ADD_W-1:0] + INCR;
    w_beat.data = in_if.data;
    if (!w_eos) w_beat.data[ADD_W-1:0] = w_sum;
    w_beat.dest = in_if.dest;
    w_beat.last = in_if.last;
  end

  sb_skid_buf #(.W($bits(sb_beat_t))) u_skid (
    .clk          (clk),
    .nreset       (nreset),
    .i_push       (w_accept),
    .i_data       (w_beat),
    .o_valid      (out_if.valid),
    .o_data       (w_out),
    .i_ready      (out_if.ready),
    .o_skid_valid (w_skid_valid),
    .o_empty      (w_empty)
  );

  assign out_if.data = w_out.data;
  assign out_if.dest = w_out.dest;
  assign out_if.last = w_out.last;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= RUN;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (w_accept && w_eos) w_next_state = DRAIN;
      DRAIN:   if (w_empty)           w_next_state = DONE;
      DONE:    w_next_state = DONE;
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    w_in_ready = r_up && (r_state == RUN) && !w_skid_valid;
    done       = (r_state == DONE);
  end

  assign in_if.ready = w_in_ready;

`ifdef SB_STREAM_ADD_STATS_EN
  logic [31:0] r_beat_count;
  logic [31:0] r_pkt_count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_beat_count <= '0;
      r_pkt_count  <= '0;
    end else if (w_accept) begin
      r_beat_count <= r_beat_count + 32'd1;
      if (in_if.last) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign beat_count = r_beat_count;
  assign pkt_count  = r_pkt_count;
`else
  assign beat_count = 32'd0;
  assign pkt_count  = 32'd0;
`endif

endmodule

// File: tb/tb_sb_stream_add_stage.sv
// tb_sb_stream_add_stage: directed bench with a queue-based reference model
// for sb_stream_add_stage (DW=256, ADD_W=64, INCR=42).
module tb_sb_stream_add_stage;

  localparam int DW = 256;
  localparam logic [191:0] UP1 = 192'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789_ABCD_EF01_2345_6789;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        done;
  logic [31:0] beat_count;
  logic [31:0] pkt_count;

  sb_stream_add_stage_if #(.DW(DW)) in_if ();
  sb_stream_add_stage_if #(.DW(DW)) out_if ();

  sb_stream_add_stage #(.DW(DW), .ADD_W(64), .INCR(64'd42)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_if      (in_if),
    .out_if     (out_if),
    .done       (done),
    .beat_count (beat_count),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [31:0]   dest;
    logic          last;
  } exp_t;

  exp_t          q[$];
  logic [63:0]   obs[$];
  int            errors = 0;
  int            checks = 0;
  int            nb_model = 0;
  int            np_model = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic [31:0]   held_dest;
  logic          held_last;
  logic          seen_eos = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Low 64 bits get +42 mod 2^64, everything else unchanged; EOS untouched.
  function automatic logic [DW-1:0] model_xform(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (d != {DW{1'b1}}) r[63:0] = d[63:0] + 64'd42;
    return r;
  endfunction

  // Compare process: everything here is stable at the falling edge.
  always @(negedge clk) begin
    if (!nreset) begin
      q.delete();
      held_v   = 1'b0;
      nb_model = 0;
      np_model = 0;
    end else begin
      if (held_v) begin
        chk("hold_valid", DW'(out_if.valid), DW'(1));
        chk("hold_data", out_if.data, held_d);
        chk("hold_dest", DW'(out_if.dest), DW'(held_dest));
        chk("hold_last", DW'(out_if.last), DW'(held_last));
      end
      if (out_if.valid && out_if.ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", DW'(1), DW'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_if.data, e.d);
          chk("out_dest", DW'(out_if.dest), DW'(e.dest));
          chk("out_last", DW'(out_if.last), DW'(e.last));
        end
        obs.push_back(out_if.data[63:0]);
        if (out_if.data == {DW{1'b1}}) seen_eos = 1'b1;
      end
      held_v    = out_if.valid && !out_if.ready;
      held_d    = out_if.data;
      held_dest = out_if.dest;
      held_last = out_if.last;
      if (in_if.valid && in_if.ready) begin
        exp_t n;
        n.d    = model_xform(in_if.data);
        n.dest = in_if.dest;
        n.last = in_if.last;
        q.push_back(n);
        nb_model++;
        if (in_if.last) np_model++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d, input logic [31:0] dst, input logic lst);
    in_if.valid = v;
    in_if.data  = d;
    in_if.dest  = dst;
    in_if.last  = lst;
  endtask

  initial begin
    int  idx;
    logic acc;
    logic saw_low;
    logic timeout;
    logic [DW-1:0] beats [3];

    set_in(1'b0, '0, 32'd0, 1'b0);
    out_if.ready = 1'b1;
    tick();
    tick();
    chk("reset_out_valid", DW'(out_if.valid), DW'(0));
    chk("reset_done", DW'(done), DW'(0));
    chk("reset_in_ready", DW'(in_if.ready), DW'(0));
    chk("reset_out_data", out_if.data, '0);
    chk("reset_out_dest", DW'(out_if.dest), DW'(0));
    chk("reset_out_last", DW'(out_if.last), DW'(0));
    chk("reset_beat_count", DW'(beat_count), DW'(0));
    nreset = 1'b1;
    tick();
    chk("ready_after_release", DW'(in_if.ready), DW'(1));

    // Single beat
    set_in(1'b1, {UP1, 64'h10}, 32'd3, 1'b1);
    tick();
    in_if.valid = 1'b0;
    chk("single_valid", DW'(out_if.valid), DW'(1));
    chk("single_low", DW'(out_if.data[63:0]), DW'(64'h3A));
    chk("single_upper", DW'(out_if.data[255:64]), DW'(UP1));
    chk("single_dest", DW'(out_if.dest), DW'(3));
    chk("single_last", DW'(out_if.last), DW'(1));
    tick();

    // Wrap of low field; bit 64 must not see the carry
    set_in(1'b1, {192'h2, 64'hFFFF_FFFF_FFFF_FFE0}, 32'd5, 1'b0);
    tick();
    in_if.valid = 1'b0;
    chk("wrap_low", DW'(out_if.data[63:0]), DW'(64'h0A));
    chk("wrap_bit64", DW'(out_if.data[64]), DW'(0));
    chk("wrap_bit65", DW'(out_if.data[65]), DW'(1));
    tick();

    // Backpressure: out_ready low for cycles 3..6
    obs.delete();
    idx = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 20; c++) begin
      out_if.ready = !(c >= 3 && c <= 6);
      if (idx < 8) set_in(1'b1, DW'(idx), 32'(idx), idx == 7);
      else         in_if.valid = 1'b0;
      acc = in_if.valid && in_if.ready;
      if (!in_if.ready) saw_low = 1'b1;
      tick();
      if (acc) idx++;
    end
    out_if.ready = 1'b1;
    in_if.valid  = 1'b0;
    chk("bp_ready_fell", DW'(saw_low), DW'(1));
    chk("bp_accepted", DW'(idx), DW'(8));
    chk("bp_out_count", DW'(obs.size()), DW'(8));
    for (int k = 0; k < 8 && k < obs.size(); k++)
      chk("bp_out_value", DW'(obs[k]), DW'(42 + k));

    // Full throughput: 100 beats in 101 cycles
    obs.delete();
    idx = 0;
    for (int c = 0; c < 101; c++) begin
      if (idx < 100) set_in(1'b1, DW'(idx + 100), 32'(idx), (idx % 10) == 9);
      else           in_if.valid = 1'b0;
      acc = in_if.valid && in_if.ready;
      tick();
      if (acc) idx++;
    end
    in_if.valid = 1'b0;
    chk("tp_accepted", DW'(idx), DW'(100));
    chk("tp_out_count", DW'(obs.size()), DW'(100));
    for (int k = 0; k < 100 && k < obs.size(); k++)
      chk("tp_out_value", DW'(obs[k]), DW'(142 + k));

    // EOS with out_ready low for 2 cycles
    obs.delete();
    beats[0] = DW'(1);
    beats[1] = DW'(2);
    beats[2] = {DW{1'b1}};
    idx = 0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      out_if.ready = (c >= 2);
      set_in(1'b1, beats[idx], 32'd9, idx == 2);
      acc = in_if.valid && in_if.ready;
      tick();
      if (acc) idx++;
    end
    chk("eos_accepted", DW'(idx), DW'(3));
    chk("eos_in_ready_low", DW'(in_if.ready), DW'(0));
    set_in(1'b1, DW'(64'h55), 32'd1, 1'b0);
    timeout = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!out_if.valid) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
    chk("eos_drain_timeout", DW'(timeout), DW'(0));
    chk("done_not_early", DW'(done), DW'(0));
    tick();
    chk("done_set", DW'(done), DW'(1));
    chk("done_out_valid", DW'(out_if.valid), DW'(0));
    chk("done_in_ready", DW'(in_if.ready), DW'(0));
    tick();
    tick();
    tick();
    chk("done_sticky", DW'(done), DW'(1));
    chk("done_ignores_in", DW'(out_if.valid), DW'(0));
    chk("eos_seen", DW'(seen_eos), DW'(1));
    chk("eos_out_count", DW'(obs.size()), DW'(3));
    if (obs.size() == 3) begin
      chk("eos_out0", DW'(obs[0]), DW'(43));
      chk("eos_out1", DW'(obs[1]), DW'(44));
      chk("eos_out2", DW'(obs[2]), DW'(64'hFFFF_FFFF_FFFF_FFFF));
    end
`ifdef SB_STREAM_ADD_STATS_EN
    chk("beat_count_model", DW'(beat_count), DW'(nb_model));
    chk("pkt_count_model", DW'(pkt_count), DW'(np_model));
    chk("beat_count_lit", DW'(beat_count), DW'(113));
    chk("pkt_count_lit", DW'(pkt_count), DW'(13));
`else
    chk("beat_count_off", DW'(beat_count), DW'(0));
    chk("pkt_count_off", DW'(pkt_count), DW'(0));
`endif

    // Reset mid-stall with two beats buffered
    in_if.valid = 1'b0;
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    tick();
    out_if.ready = 1'b0;
    set_in(1'b1, DW'(7), 32'd2, 1'b0);
    tick();
    set_in(1'b1, DW'(8), 32'd2, 1'b1);
    tick();
    in_if.valid = 1'b0;
    chk("stall_two_buffered", DW'(in_if.ready), DW'(0));
    chk("stall_out_valid", DW'(out_if.valid), DW'(1));
    #2;
    nreset = 1'b0;
    #1;
    chk("rst_out_valid", DW'(out_if.valid), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_in_ready", DW'(in_if.ready), DW'(0));
    @(posedge clk);
    #1;
    nreset = 1'b1;
    out_if.ready = 1'b1;
    tick();
    chk("rel_in_ready", DW'(in_if.ready), DW'(1));
    chk("rel_out_valid", DW'(out_if.valid), DW'(0));
    chk("rel_beat_count", DW'(beat_count), DW'(0));
    chk("rel_pkt_count", DW'(pkt_count), DW'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
